// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: 2-entry word FIFO feeding a shift register that emits
// one bit per clock, with a constant idle bit whenever no word is in flight.
module bit_serializer #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sbusy,
    output logic         word_done,
    output logic [1:0]   fifo_cnt,
    output logic [0:0]   dbg_state
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [W-1:0]  r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_cnt;

    logic [0:0]    r_state;
    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_bits_left;
    logic          r_sout;
    logic          r_sbusy;
    logic          r_word_done;

    logic          w_push;
    logic          w_slot_free;
    logic          w_load;
    logic [W-1:0]  w_head;

    // Handshake: a word transfers on a rising edge where din_valid and din_ready are both high;
    // while din_ready is low the source must hold din/din_valid unchanged.
    assign din_ready   = (r_cnt != 2'd2) & ~rst;
    assign w_push      = din_valid & din_ready;
    assign w_slot_free = (r_state == S_IDLE) | (r_bits_left == '0);
    assign w_load      = w_slot_free & (r_cnt != 2'd0);
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_load) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_load};
        end
    end

    // r_shreg holds the bits not yet driven, aligned so the next one sits at the output end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_sout      <= IDLE_BIT;
            r_sbusy     <= 1'b0;
            r_word_done <= 1'b0;
        end else if (w_load) begin
            r_state     <= S_SHIFT;
            r_sout      <= MSB_FIRST ? w_head[W-1] : w_head[0];
            r_shreg     <= MSB_FIRST ? (w_head << 1) : (w_head >> 1);
            r_bits_left <= CW'(W - 1);
            r_sbusy     <= 1'b1;
            r_word_done <= 1'b0;
        end else if (r_state == S_SHIFT && r_bits_left != '0) begin
            r_sout      <= MSB_FIRST ? r_shreg[W-1] : r_shreg[0];
            r_shreg     <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            r_bits_left <= r_bits_left - CW'(1);
            r_sbusy     <= 1'b1;
            r_word_done <= (r_bits_left == CW'(1));
        end else if (r_state == S_SHIFT) begin
            r_state     <= S_IDLE;
            r_sout      <= IDLE_BIT;
            r_sbusy     <= 1'b0;
            r_word_done <= 1'b0;
        end
    end

    assign sout      = r_sout;
    assign sbusy     = r_sbusy;
    assign word_done = r_word_done;
    assign fifo_cnt  = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: cycle-accurate bit-stream scoreboard on the default instance,
// plus a directed LSB-first / idle-0 instance.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, sout, sbusy, word_done;
    logic [1:0]   fifo_cnt;
    logic [0:0]   dbg_state;

    logic [W-1:0] l_din = '0;
    logic         l_valid = 1'b0;
    logic         l_ready, l_sout, l_sbusy, l_word_done;
    logic [1:0]   l_cnt;
    logic [0:0]   l_state;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int           exp_t[$];
    int           last_end = 0;
    logic         bit_log[$];
    bit           seen_full = 1'b0;

    bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sbusy(sbusy), .word_done(word_done), .fifo_cnt(fifo_cnt),
        .dbg_state(dbg_state)
    );

    bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
        .sout(l_sout), .sbusy(l_sbusy), .word_done(l_word_done), .fifo_cnt(l_cnt),
        .dbg_state(l_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: each accepted word occupies W consecutive cycles on the line, starting one
    // edge after acceptance or right after the previous word, whichever is later.
    always @(negedge clk) begin
        int idx;
        int pend;
        int start;
        logic e_bit;
        if (exp_q.size() > 0 && cyc >= exp_t[0]) begin
            idx   = cyc - exp_t[0];
            e_bit = MSB_BIT(exp_q[0], idx);
            chk("sbusy", sbusy, 1);
            chk("sout", sout, e_bit);
            chk("word_done", word_done, (idx == W - 1));
            if (idx >= W - 1) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
            end
        end else begin
            chk("sbusy_idle", sbusy, 0);
            chk("sout_idle", sout, 1);
            chk("word_done_idle", word_done, 0);
        end
        pend = 0;
        foreach (exp_t[i]) if (exp_t[i] > cyc) pend++;
        chk("fifo_cnt", fifo_cnt, pend);
        chk("din_ready", din_ready, (pend != 2) && !rst);
        if (sbusy) bit_log.push_back(sout);
        if (!rst && !din_ready) seen_full = 1'b1;
        if (rst) begin
            exp_q.delete();
            exp_t.delete();
            last_end = 0;
        end else if (din_valid && din_ready) begin
            start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            exp_q.push_back(din);
            exp_t.push_back(start);
            last_end = start + W - 1;
        end
    end

    function automatic logic MSB_BIT(input logic [W-1:0] w, input int idx);
        return w[W - 1 - idx];
    endfunction

    task automatic send(input logic [W-1:0] w);
        bit ok = 1'b0;
        @(posedge clk);
        #2;
        din       = w;
        din_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (din_ready && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout word=%0h", w);
        end
    endtask

    task automatic drop_valid();
        @(posedge clk);
        #2;
        din_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] log_bits(input int first, input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[30:0], bit_log[first + k]};
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        int hits;
        int hit_pos;
        bit ok;

        // Reset hold with din_valid asserted
        din_valid = 1'b1;
        din       = 8'h5C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rst_sout", sout, 1);
            chk("rst_sbusy", sbusy, 0);
            chk("rst_din_ready", din_ready, 0);
        end
        @(posedge clk);
        #2;
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_din_ready", din_ready, 1);
        chk("post_rst_fifo_cnt", fifo_cnt, 0);

        // Single word
        bit_log.delete();
        send(8'h6A);
        drop_valid();
        wait_cycles(12);
        chk("single_len", bit_log.size(), 8);
        if (bit_log.size() == 8) chk("single_bits", log_bits(0, 8), 32'h6A);

        // Back-to-back words and the downstream pattern detector
        bit_log.delete();
        send(8'h6A);
        send(8'hBF);
        drop_valid();
        wait_cycles(20);
        chk("b2b_len", bit_log.size(), 16);
        if (bit_log.size() == 16) begin
            chk("b2b_bits", log_bits(0, 16), 32'h6ABF);
            pat     = 9'b011010101;
            hits    = 0;
            hit_pos = 0;
            for (int s = 0; s + 9 <= 16; s++) begin
                ok = 1'b1;
                for (int k = 0; k < 9; k++) if (bit_log[s + k] !== pat[8 - k]) ok = 1'b0;
                if (ok) begin
                    hits++;
                    hit_pos = s + 9;
                end
            end
            chk("detector_hits", hits, 1);
            chk("detector_pos", hit_pos, 9);
        end

        // FIFO full: filler word, then three words on consecutive cycles
        seen_full = 1'b0;
        send(8'hC3);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        drop_valid();
        wait_cycles(45);
        chk("fifo_full_seen", seen_full, 1);

        // Reset mid-word with one word queued
        bit_log.delete();
        send(8'hFF);
        send(8'hA5);
        drop_valid();
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bit_log.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midword_reach", ok, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midword_sout", sout, 1);
        chk("midword_cnt", fifo_cnt, 0);
        wait_cycles(20);
        chk("midword_no_resume", bit_log.size(), 3);

        // LSB-first, idle 0
        @(posedge clk);
        #2;
        l_din   = 8'h01;
        l_valid = 1'b1;
        @(negedge clk);
        chk("lsb_ready", l_ready, 1);
        @(posedge clk);
        #2;
        l_valid = 1'b0;
        @(negedge clk);
        chk("lsb_cnt", l_cnt, 1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("lsb_sout", l_sout, (i == 1) ? 1 : 0);
            chk("lsb_sbusy", l_sbusy, (i <= 8) ? 1 : 0);
            chk("lsb_done", l_word_done, (i == 8) ? 1 : 0);
        end

        // Randomized traffic with random gaps
        for (int n = 0; n < 40; n++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                drop_valid();
                wait_cycles($urandom_range(0, 12));
            end
        end
        drop_valid();
        wait_cycles(40);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial pattern detector. Accepts W-bit words over a valid/ready handshake and buffers up to two of them in a 2-entry FIFO. Shifts each word out one bit per clock on `sout`, MSB first by default, back-to-back with no gaps. When no data is queued it drives a constant idle bit, so the downstream detector (one bit per clock, no valid qualifier) always sees a defined stream.

## Interface
- `W`, default 8: word width, legal 2..32.
- `MSB_FIRST`, default 1: 1 sends bit W-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 1: value driven on `sout` when no word is being shifted.

Reset is `rst`: synchronous, active-high. The clock is `clk`.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `din`  in  W  word to send
- `din_valid`  in  1  `din` is valid this cycle
- `din_ready`  out  1  block can accept a word this cycle
- `sout`  out  1  registered serial bit to the detector
- `sbusy`  out  1  registered; `sout` carries a data bit (not idle)
- `word_done`  out  1  registered; high for the cycle the last bit of a word is on `sout`
- `fifo_cnt`  out  2  number of queued words not yet loaded into the shifter (0..2)

## Operation
- FIFO: 2 entries.
  - Push on a clock edge when `din_valid & din_ready`.
  - Pop when the shifter loads.
  - `din_ready = (fifo_cnt != 2) & ~rst`, combinational from registered count.
  - A push while full cannot occur. If `din_valid` is high while `din_ready` is low, the word is ignored and must be held by the source.
- Shifter: W-bit shift register plus a bit counter of width clog2(W)+1.
  - Two states: IDLE and SHIFT.
- IDLE:
  - `sout` = `IDLE_BIT`, `sbusy` = 0.
  - If the FIFO is non-empty at an edge, load the head word, pop, and drive its first bit on `sout` from that edge. Go to SHIFT with the counter at W-1 bits remaining.
- SHIFT: each edge drives the next bit.
  - When the bit being driven is the last bit, `word_done` = 1 for that cycle.
  - At the edge ending the last bit:
    - FIFO non-empty: load the next word immediately, so its first bit directly follows with zero idle cycles.
    - FIFO empty: return to IDLE; `sout` = `IDLE_BIT` from that edge.
- Simultaneous push and pop in the same edge: count unchanged, data order preserved (FIFO semantics).
- A word pushed into an empty FIFO while the shifter is IDLE is not bypassed. It must pass through the FIFO, which fixes latency.
- Reset at any point:
  - Discards the FIFO and the in-flight word.
  - `sout` = `IDLE_BIT`, `sbusy` = 0, `word_done` = 0, `fifo_cnt` = 0.
  - No partial word is resumed.

## Timing
- Reset values:
  - `sout` = `IDLE_BIT`
  - `sbusy` = 0
  - `word_done` = 0
  - `fifo_cnt` = 0
  - `din_ready` = 0 during reset, 1 on the first cycle after reset deasserts.
- Latency: a word accepted at edge E0 (shifter IDLE, FIFO empty) appears as follows:
  - `fifo_cnt` = 1 after E0.
  - First bit on `sout` after E1; `fifo_cnt` back to 0.
  - Last bit on `sout` after E(W), with `word_done` high in that cycle.
- Throughput: one bit per clock. A sustained source keeps `sbusy` high continuously.
- `din_ready` may drop only when the second entry fills. With W ≥ 2 the source is never stalled for more than W-1 cycles.
- All outputs except `din_ready` are registered. There is no combinational path from `din`/`din_valid` to `sout`.

## Test plan
- Reset hold:
  - Stimulus: assert `rst` for 3 cycles with `din_valid` = 1.
  - Required: `sout` = 1, `sbusy` = 0, `din_ready` = 0 throughout; after release `din_ready` = 1 and `fifo_cnt` = 0.
- Single word, W=8:
  - Stimulus: `din` = 8'h6A accepted at E0.
  - Required: `sout` = 0,1,1,0,1,0,1,0 after E1..E8; `word_done` high only after E8; `sout` = 1 and `sbusy` = 0 after E9.
- Back-to-back:
  - Stimulus: 8'h6A then 8'hBF.
  - Required: 16 contiguous bits 0110101010111111 with no idle gap.
  - Required: the downstream 011010101 detector fires once, on the 9th serial bit.
- FIFO full:
  - Stimulus: push 3 words on consecutive cycles while the shifter is busy.
  - Required: `din_ready` = 0 once `fifo_cnt` = 2; the third word is accepted only after the next load; all words are emitted in order.
- Reset mid-word:
  - Stimulus: assert `rst` after bit 3 of 8'hFF with one word queued.
  - Required: `sout` = 1, `fifo_cnt` = 0 next cycle; no remaining bits are emitted after release.
- LSB-first, `MSB_FIRST` = 0, `IDLE_BIT` = 0:
  - Stimulus: 8'h01.
  - Required: `sout` = 1,0,0,0,0,0,0,0, then 0 when idle.
